// File: rtl/lms_pkg.sv
// Shared FSM state type and fixed-point helpers for the LMS predictor.
package lms_pkg;

  typedef enum logic [1:0] {StIdle, StUpd, StMac, StOut} state_e;

  // Full-precision accumulator width: product width plus growth for ORDER terms plus sign guard.
  function automatic int unsigned acc_width(int unsigned data_w, int unsigned order);
    return 2 * data_w + $clog2(order) + 1;
  endfunction

  // Half an LSB of the output grid, added before the arithmetic shift to round half up.
  function automatic int round_const(int unsigned frac_w);
    return (frac_w == 0) ? 0 : (1 << (frac_w - 1));
  endfunction

  function automatic logic signed [63:0] sat_to(int unsigned width, logic signed [63:0] value);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/lms_mac_unit.sv
// Single signed multiplier with a clearable accumulator and round/saturate output.
// The raw product is exported only when LMS_UPDATE_EN is defined (used by weight update).
module lms_mac_unit
  import lms_pkg::*;
#(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned ORDER  = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic signed [DATA_W-1:0]   a_i,
  input  logic signed [DATA_W-1:0]   b_i,
`ifdef LMS_UPDATE_EN
  output logic signed [2*DATA_W-1:0] prod_o,
`endif
  output logic signed [DATA_W-1:0]   res_o,
  output logic                       res_sat_o
);

  localparam int unsigned AccW = acc_width(DATA_W, ORDER);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [AccW-1:0]     acc_q, acc_d, acc_sum, acc_rnd;
  logic signed [63:0]         rnd_wide, rnd_sat;

  assign prod = a_i * b_i;
`ifdef LMS_UPDATE_EN
  assign prod_o = prod;
`endif

  // The result reflects the accumulator including the product of this cycle.
  assign acc_sum  = acc_q + AccW'(prod);
  assign acc_rnd  = (acc_sum + AccW'(round_const(FRAC_W))) >>> FRAC_W;
  assign rnd_wide = 64'(acc_rnd);
  assign rnd_sat  = sat_to(DATA_W, rnd_wide);

  assign res_o     = DATA_W'(rnd_sat);
  assign res_sat_o = (rnd_sat != rnd_wide);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/lms_predictor.sv
// N-tap fixed-point linear predictor with a time-shared multiplier and valid/ready handshakes.
// Optional LMS weight adaptation is enabled by defining LMS_UPDATE_EN.
module lms_predictor
  import lms_pkg::*;
#(
  parameter int unsigned DATA_W   = 9,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned ORDER    = 3,
  parameter int unsigned MU_SHIFT = 4,
  localparam int unsigned IdxW    = (ORDER > 1) ? $clog2(ORDER) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] x_in_i,
  input  logic                     w_load_i,
  input  logic [IdxW-1:0]          w_idx_i,
  input  logic signed [DATA_W-1:0] w_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] x_hat_o,
  output logic signed [DATA_W-1:0] err_o,
  output logic                     sat_o
);

  state_e state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic cnt_last;

  logic signed [DATA_W-1:0] hist_q [ORDER];
  logic signed [DATA_W-1:0] w_q    [ORDER];
  logic signed [DATA_W-1:0] x_hat_q, err_q, err_next_q;
  logic                     sat_q, err_sat_q;

  logic signed [63:0]       err_wide;
  logic signed [DATA_W-1:0] err_clip;
  logic                     err_clipped;

  logic signed [DATA_W-1:0] mac_a, mac_b, mac_res;
  logic                     mac_sat;

`ifdef LMS_UPDATE_EN
  logic signed [DATA_W-1:0]   x_lat_q;
  logic signed [2*DATA_W-1:0] mac_prod;
  logic signed [DATA_W-1:0]   w_upd;
`endif

  assign cnt_last    = (cnt_q == IdxW'(ORDER - 1));
  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StOut);
  assign x_hat_o     = x_hat_q;
  assign err_o       = err_q;
  assign sat_o       = sat_q;

  // The registered x_hat doubles as the stored prediction of the next sample.
  assign err_wide    = 64'(x_in_i) - 64'(x_hat_q);
  assign err_clip    = DATA_W'(sat_to(DATA_W, err_wide));
  assign err_clipped = (64'(err_clip) != err_wide);

  always_comb begin
    mac_a = w_q[cnt_q];
    mac_b = hist_q[cnt_q];
`ifdef LMS_UPDATE_EN
    if (state_q == StUpd) mac_a = err_next_q;
`endif
  end

`ifdef LMS_UPDATE_EN
  // Truncating step: err*x scaled down by the weight fraction and the step-size shift.
  assign w_upd = DATA_W'(sat_to(DATA_W,
                   64'(w_q[cnt_q]) + 64'(mac_prod >>> (FRAC_W + MU_SHIFT))));
`endif

  lms_mac_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ORDER  (ORDER)
  ) u_mac (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_i     (state_q != StMac),
    .en_i      (state_q == StMac),
    .a_i       (mac_a),
    .b_i       (mac_b),
`ifdef LMS_UPDATE_EN
    .prod_o    (mac_prod),
`endif
    .res_o     (mac_res),
    .res_sat_o (mac_sat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          cnt_d = '0;
`ifdef LMS_UPDATE_EN
          state_d = StUpd;
`else
          state_d = StMac;
`endif
        end
      end
`ifdef LMS_UPDATE_EN
      StUpd: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StMac;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
`endif
      StMac: begin
        if (cnt_last) begin
          state_d = StOut;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      StOut: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      x_hat_q    <= '0;
      err_q      <= '0;
      err_next_q <= '0;
      err_sat_q  <= 1'b0;
      sat_q      <= 1'b0;
`ifdef LMS_UPDATE_EN
      x_lat_q    <= '0;
`endif
      for (int k = 0; k < int'(ORDER); k++) begin
        hist_q[k] <= '0;
        w_q[k]    <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle) begin
        if (w_load_i && (32'(w_idx_i) < ORDER)) w_q[w_idx_i] <= w_data_i;
        if (in_valid_i) begin
          err_next_q <= err_clip;
          err_sat_q  <= err_clipped;
`ifdef LMS_UPDATE_EN
          x_lat_q <= x_in_i;
`else
          for (int k = int'(ORDER) - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
          hist_q[0] <= x_in_i;
`endif
        end
      end
`ifdef LMS_UPDATE_EN
      // Update uses the pre-shift history; the new sample enters as UPD hands over to MAC.
      if (state_q == StUpd) begin
        w_q[cnt_q] <= w_upd;
        if (cnt_last) begin
          for (int k = int'(ORDER) - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
          hist_q[0] <= x_lat_q;
        end
      end
`endif
      if ((state_q == StMac) && cnt_last) begin
        x_hat_q <= mac_res;
        err_q   <= err_next_q;
        sat_q   <= mac_sat | err_sat_q;
      end
    end
  end

endmodule

// File: doc/lms_predictor.md
Name: lms_predictor

Overview:
- N-tap fixed-point linear predictor, parametrised in sample width, fraction bits and order; next generation of the fixed 3-tap, 9-bit, Q4 predictor.
- Each accepted sample x[n] produces the error of the stored prediction of x[n], then a prediction of x[n+1] from the updated history.
- One multiplier is time-shared across taps by an FSM, with valid/ready handshakes on input and output.
- Sits between the sample source and the residual encoder.
- Optional LMS weight adaptation.

Parameters:
- DATA_W, 9, signed width of samples, weights, x_hat and err.
- FRAC_W, 4, fractional bits of weights; samples are integers, so Q4 weights give scale 16.
- ORDER, 3, number of taps (>=1).
- MU_SHIFT, 4, LMS step size as a right shift; used only with LMS_UPDATE_EN.

Ports:
- Clk, in, 1, clock; all logic on posedge.
- reset, in, 1, synchronous, active-high.
- in_valid, in, 1, x_in valid.
- in_ready, out, 1, block can accept a sample.
- x_in, in, DATA_W, signed sample x[n].
- w_load, in, 1, weight write strobe.
- w_idx, in, $clog2(ORDER) (min 1), tap index; w0 multiplies x[n-1].
- w_data, in, DATA_W, signed Q(FRAC_W) weight.
- out_valid, out, 1, x_hat/err valid.
- out_ready, in, 1, consumer accepts the result.
- x_hat, out, DATA_W, signed prediction of x[n+1].
- err, out, DATA_W, signed x[n] minus the stored prediction of x[n].
- sat, out, 1, x_hat or err saturated in this result.

Behaviour:
- Reset, on a sync reset cycle: state IDLE; delay line, weights, stored prediction, x_hat, err, sat and out_valid all 0; in_ready 1 from the next cycle. Reset overrides every state, including mid-MAC, mid-UPD and OUT; the in-flight sample is discarded with no output.
- States: IDLE -> [UPD] -> MAC -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: err_next = sat(x_in - pred); x_in is latched.
  - With the feature off, x_in shifts into the delay line (hist[0]=x_in, hist[k]=hist[k-1]) and the FSM goes to MAC.
- UPD (feature only): ORDER cycles, one tap per cycle; described under Optional Feature.
- MAC:
  - ORDER cycles; cycle k does acc += w[k]*hist[k].
  - Products are 2*DATA_W bits; acc is 2*DATA_W+$clog2(ORDER)+1 bits, full precision, no intermediate overflow.
- MAC end:
  - pred = sat((acc + 2^(FRAC_W-1)) >>> FRAC_W), i.e. round half up then arithmetic shift, saturated to DATA_W signed.
  - x_hat=pred and err=err_next are registered; sat = either value clipped; go to OUT.
- OUT:
  - out_valid=1; x_hat, err and sat are held stable until out_ready.
  - On the out_valid&&out_ready cycle, go to IDLE; in_ready rises the next cycle.
  - in_ready=0 in every state except IDLE.
- Latency: accept in cycle 0; out_valid in cycle ORDER+1 (feature off) or 2*ORDER+1 (feature on).
- Throughput: one sample per ORDER+2 cycles when out_ready is held high.
- Weight writes:
  - Take effect only in IDLE; w_load in any other state is ignored.
  - A write and an in_valid in the same IDLE cycle: the write lands first and the MAC uses the new weight.
  - An out-of-range w_idx is ignored.
- x_hat and err stay at their last values after the handshake; consumers qualify them with out_valid.

Optional Feature:
- Macro: LMS_UPDATE_EN.
- Defined:
  - After accept, the FSM enters UPD for ORDER cycles, using the pre-shift history (the regressor that formed pred).
  - Each cycle: w[k] = sat(w[k] + ((err_next*hist[k]) >>> (FRAC_W+MU_SHIFT))), truncating.
  - The shift of x_in into the delay line happens on the UPD->MAC transition; the MAC then uses the updated weights.
  - An external w_load still applies only in IDLE.
- Undefined: no UPD state and no update datapath; weights change only via w_load.

Decomposition:
- Package lms_pkg:
  - State enum (IDLE, UPD, MAC, OUT).
  - Accumulator-width function.
  - Saturate function sat_to(width, value).
  - Rounding constant.
- Sub-module lms_mac_unit: one signed multiplier plus accumulator with clear/enable and round/saturate output. It is reused by UPD for its multiply.

Test Plan:
- Basic prediction (w=[8,4,0], ORDER=3, out_ready=1):
  - Feed x_in=16 -> err=16, x_hat=8.
  - Then x_in=32 -> err=24, x_hat=20.
  - out_valid comes 4 cycles after each accept.
- Rounding (w0=1, others 0):
  - x_in=8 -> x_hat=1.
  - Next x_in=-8 -> x_hat=0, err=-9.
  - sat=0 throughout.
- Saturation: w0=255, x_in=255 -> x_hat=255 (raw 4064), sat=1. Next x_in=-256 -> err=-256 clipped, sat=1.
- Backpressure and weight-write gating:
  - out_ready low 5 cycles after out_valid -> x_hat/err stable, in_ready=0, in_valid ignored.
  - A w_load during MAC does not change the weights (readback through a later prediction).
- Reset in the 2nd MAC cycle -> next cycle out_valid=0, in_ready=1, x_hat=err=0. A following x_in=16 with w=0 gives err=16, x_hat=0.
- LMS_UPDATE_EN, MU_SHIFT=4, weights 0:
  - Feed 16, then 16 -> second err=16 and w0 becomes 1.
  - Third sample x_in=0 -> err=-1 (pred 1); out_valid latency 7 cycles.
